// File: rtl/seq_goto_checker.sv
// seq_goto_checker: hardware checker for "a |=> b[->COUNT] ##1 c" (MODE 1: b[=COUNT] ##1 c style),
// tracking up to SLOTS overlapping attempts with pass/fail pulses and saturating totals.
module seq_goto_checker #(
  parameter int COUNT   = 3,
  parameter int SLOTS   = 4,
  parameter int MODE    = 0,
  parameter int TIMEOUT = 0,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             pass,
  output logic             fail,
  output logic             timeout,
  output logic             overflow,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [SLOTS-1:0] busy
);
  localparam int TW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  typedef enum logic [1:0] {IDLE, COUNTING, AWAIT_C} state_t;
  state_t           r_st   [SLOTS];
  logic [7:0]       r_bcnt [SLOTS];
  logic [TW-1:0]    r_tcnt [SLOTS];
  state_t           w_st   [SLOTS];
  logic [7:0]       w_bcnt [SLOTS];
  logic [7:0]       w_bnext[SLOTS];
  logic [TW-1:0]    w_tcnt [SLOTS];
  logic [SLOTS-1:0] w_idle, w_alloc, w_pass, w_fail, w_to, w_dl;
  logic             w_ovf;
  logic [CNT_W:0]   w_psum, w_fsum;
  always_comb begin
    w_idle = '0;
    for (int i = 0; i < SLOTS; i++) w_idle[i] = r_st[i] == IDLE;
  end
  assign busy = ~w_idle;
  // lowest-index idle slot wins; a slot freed this edge is still busy here
  assign w_alloc = (a && en) ? w_idle & (~w_idle + SLOTS'(1)) : '0;
  assign w_ovf   = a && en && w_idle == '0;
  always_comb begin
    w_pass = '0;
    w_fail = '0;
    w_to   = '0;
    w_dl   = '0;
    for (int i = 0; i < SLOTS; i++) begin
      w_bnext[i] = r_bcnt[i] + 8'(b);
      w_dl[i]    = TIMEOUT > 0 && r_st[i] != IDLE && int'(r_tcnt[i]) == TIMEOUT - 1;
      w_pass[i]  = r_st[i] == AWAIT_C && c;
      w_to[i]    = w_dl[i] && !w_pass[i];
      w_fail[i]  = w_to[i] || (r_st[i] == AWAIT_C && !c && (MODE == 0 || b));
      w_st[i]    = w_alloc[i] ? COUNTING :
                   (w_pass[i] || w_fail[i]) ? IDLE :
                   (r_st[i] == COUNTING && b && w_bnext[i] == 8'(COUNT)) ? AWAIT_C : r_st[i];
      w_bcnt[i]  = w_alloc[i] ? '0 : (r_st[i] == COUNTING && b) ? w_bnext[i] : r_bcnt[i];
      w_tcnt[i]  = w_alloc[i] ? '0 : r_st[i] != IDLE ? r_tcnt[i] + TW'(1) : r_tcnt[i];
    end
  end
  assign w_psum = {1'b0, pass_cnt} + (CNT_W + 1)'($countones(w_pass));
  assign w_fsum = {1'b0, fail_cnt} + (CNT_W + 1)'($countones(w_fail));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st     <= '{default: IDLE};
      r_bcnt   <= '{default: '0};
      r_tcnt   <= '{default: '0};
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else if (clr) begin
      r_st     <= '{default: IDLE};
      r_bcnt   <= '{default: '0};
      r_tcnt   <= '{default: '0};
      pass     <= 1'b0;
      fail     <= 1'b0;
      timeout  <= 1'b0;
      overflow <= 1'b0;
      pass_cnt <= '0;
      fail_cnt <= '0;
    end else begin
      r_st     <= w_st;
      r_bcnt   <= w_bcnt;
      r_tcnt   <= w_tcnt;
      pass     <= |w_pass;
      fail     <= |w_fail;
      timeout  <= |w_to;
      overflow <= w_ovf;
      pass_cnt <= w_psum[CNT_W] ? '1 : w_psum[CNT_W-1:0];
      fail_cnt <= w_fsum[CNT_W] ? '1 : w_fsum[CNT_W-1:0];
    end
  end
endmodule

// File: tb/tb_seq_goto_checker.sv
// tb_seq_goto_checker: directed vector table plus hand sequences for seq_goto_checker.
module tb_seq_goto_checker;
  logic clk = 0, rst_n = 0, en = 1, clr = 0, a = 0, b = 0, c = 0;
  logic p0, f0, t0, o0, p1, f1, t1, o1, p2, f2, t2, o2;
  logic [15:0] pc0, fc0, pc1, fc1;
  logic [2:0] pc2, fc2;
  logic [3:0] bz0, bz1, bz2;
  int n_vec = 0, n_bad = 0;

  always #5 clk = ~clk;

  seq_goto_checker #(.COUNT(3), .SLOTS(4), .MODE(0), .TIMEOUT(0), .CNT_W(16)) u0 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .pass(p0), .fail(f0), .timeout(t0), .overflow(o0), .pass_cnt(pc0), .fail_cnt(fc0), .busy(bz0));
  seq_goto_checker #(.COUNT(3), .SLOTS(4), .MODE(1), .TIMEOUT(0), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .pass(p1), .fail(f1), .timeout(t1), .overflow(o1), .pass_cnt(pc1), .fail_cnt(fc1), .busy(bz1));
  seq_goto_checker #(.COUNT(3), .SLOTS(4), .MODE(0), .TIMEOUT(6), .CNT_W(3)) u2 (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .a(a), .b(b), .c(c),
    .pass(p2), .fail(f2), .timeout(t2), .overflow(o2), .pass_cnt(pc2), .fail_cnt(fc2), .busy(bz2));

  typedef struct {
    logic a, b, c, en, clr;
    logic p, f, o;
    logic [3:0] bz;
  } vec_t;
  vec_t vq[$];

  task automatic add(input logic ia, ib, ic, ien, iclr, ep, ef, eo, input logic [3:0] ebz);
    vq.push_back('{a: ia, b: ib, c: ic, en: ien, clr: iclr, p: ep, f: ef, o: eo, bz: ebz});
  endtask

  task automatic step(input logic ia, ib, ic, input logic ien = 1'b1, input logic iclr = 1'b0);
    a = ia; b = ib; c = ic; en = ien; clr = iclr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pass_seq();
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 1);
  endtask

  initial begin
    // a b c en clr | pass fail ovf busy  (outputs seen after that edge, u0)
    add(0,0,0,1,1, 0,0,0,4'b0000);
    add(1,0,0,1,0, 0,0,0,4'b0001);
    add(0,1,0,1,0, 0,0,0,4'b0001);
    add(0,1,0,1,0, 0,0,0,4'b0001);
    add(0,1,0,1,0, 0,0,0,4'b0001);
    add(0,0,1,1,0, 1,0,0,4'b0000);
    add(0,0,0,1,0, 0,0,0,4'b0000);
    add(1,0,0,1,0, 0,0,0,4'b0001);
    add(1,1,0,1,0, 0,0,0,4'b0011);
    add(1,1,0,1,0, 0,0,0,4'b0111);
    add(1,1,0,1,0, 0,0,0,4'b1111);
    add(1,0,0,1,0, 0,1,1,4'b1110);
    add(1,0,1,1,0, 0,0,0,4'b1111);
    add(0,0,0,1,1, 0,0,0,4'b0000);
    for (int k = 0; k < 2; k++) begin
      add(1,0,0,1,0, 0,0,0,4'b0001);
      add(0,0,0,1,0, 0,0,0,4'b0001);
      add(0,1,0,1,0, 0,0,0,4'b0001);
      add(0,0,0,1,0, 0,0,0,4'b0001);
      add(0,0,0,1,0, 0,0,0,4'b0001);
      add(0,1,0,1,0, 0,0,0,4'b0001);
      add(0,0,0,1,0, 0,0,0,4'b0001);
      add(0,0,0,1,0, 0,0,0,4'b0001);
      add(0,0,0,1,0, 0,0,0,4'b0001);
      add(0,1,0,1,0, 0,0,0,4'b0001);
      if (k == 0) add(0,0,1,1,0, 1,0,0,4'b0000);
      else begin
        add(0,0,0,1,0, 0,1,0,4'b0000);
        add(0,0,1,1,0, 0,0,0,4'b0000);
      end
    end
    add(1,0,0,0,0, 0,0,0,4'b0000);
    add(0,0,0,1,0, 0,0,0,4'b0000);

    #12 rst_n = 1;
    #1;
    chk("reset_state", {p0, f0, t0, o0, bz0, pc0, fc0}, 32'h0);

    foreach (vq[i]) begin
      step(vq[i].a, vq[i].b, vq[i].c, vq[i].en, vq[i].clr);
      chk($sformatf("vec%0d", i), {p0, f0, o0, t0, bz0}, {vq[i].p, vq[i].f, vq[i].o, 1'b0, vq[i].bz});
    end
    chk("table_pass_cnt", 32'(pc0), 1);
    chk("table_fail_cnt", 32'(fc0), 1);

    // two slots reaching a verdict on the same edge count twice
    step(0, 0, 0, 1, 1);
    step(1, 0, 0); step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 1);
    chk("dual_pass", {p0, f0, bz0}, {1'b1, 1'b0, 4'b0000});
    chk("dual_pass_cnt", 32'(pc0), 2);

    repeat (3) pass_seq();
    chk("pass_cnt_5", 32'(pc0), 5);
    step(0, 0, 0); step(0, 0, 0);
    step(1, 0, 0, 1, 1);
    chk("clr_with_a", {bz0, pc0, fc0, p0}, 32'h0);
    step(0, 1, 0);
    chk("clr_no_attempt", 32'(bz0), 0);

    step(0, 0, 0, 1, 1);
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    chk("m1_wait", {p1, f1, bz1}, {1'b0, 1'b0, 4'b0001});
    step(0, 0, 1);
    chk("m1_pass", {p1, f1, bz1}, {1'b1, 1'b0, 4'b0000});
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    chk("m1_extra_b_fail", {p1, f1, bz1}, {1'b0, 1'b1, 4'b0000});
    step(1, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 1, 1);
    chk("m1_c_beats_b", {p1, f1}, 2'b10);
    chk("m1_cnts", {pc1, fc1}, {16'd2, 16'd1});

    step(0, 0, 0, 1, 1);
    step(1, 0, 0);
    step(0, 1, 0); step(0, 1, 0);
    repeat (3) step(0, 0, 0);
    chk("to_before", {f2, t2, bz2}, {1'b0, 1'b0, 4'b0001});
    step(0, 0, 0);
    chk("to_fire", {p2, f2, t2, bz2}, {1'b0, 1'b1, 1'b1, 4'b0000});
    chk("to_fail_cnt", 32'(fc2), 1);
    step(1, 0, 0);
    step(0, 0, 0); step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    step(0, 0, 1);
    chk("to_pass_wins", {p2, f2, t2, bz2}, {1'b1, 1'b0, 1'b0, 4'b0000});

    step(0, 0, 0, 1, 1);
    repeat (6) pass_seq();
    chk("sat_6", 32'(pc2), 6);
    repeat (3) pass_seq();
    chk("sat_9", 32'(pc2), 7);

    step(1, 0, 0);
    step(0, 1, 0);
    #2 rst_n = 0;
    #1;
    chk("async_reset", {p0, f0, t0, o0, bz0, pc0, fc0}, 32'h0);
    #2 rst_n = 1;
    step(0, 1, 0); step(0, 1, 0); step(0, 0, 1);
    chk("post_reset", {p0, f0, bz0, pc0}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/seq_goto_checker.md
# seq_goto_checker

Synthesizable, parametrised checker for the temporal pattern "trigger |=> b goto-repeated COUNT times ##1 c", with an optional non-consecutive mode. It tracks up to SLOTS overlapping attempts and reports per-cycle pass/fail pulses and saturating totals. It sits beside the design under check, in simulation or emulation, as a hardware counterpart of the concurrent assertions used in our testbenches.

## Interface
- COUNT, 3: number of b occurrences required; 1..255.
- SLOTS, 4: maximum concurrent in-flight attempts; 1..16.
- MODE, 0: 0 = goto (c required exactly one cycle after the COUNT-th b); 1 = non-consecutive (c may arrive any later cycle, provided no further b arrives first).
- TIMEOUT, 0: maximum cycles an attempt may stay in flight; 0 = disabled.
- CNT_W, 16: width of the total counters.

- clk  in  1  sampling clock; all activity on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  when 0, no new attempts start; in-flight attempts continue.
- clr  in  1  synchronous clear: abort all attempts and zero the counters.
- a  in  1  trigger.
- b  in  1  counted event.
- c  in  1  completion condition.
- pass  out  1  at least one attempt passed at the previous edge.
- fail  out  1  at least one attempt failed at the previous edge.
- timeout  out  1  at least one of those failures was a timeout.
- overflow  out  1  a trigger was dropped at the previous edge because all slots were busy.
- pass_cnt  out  CNT_W  total passes; saturates at all-ones.
- fail_cnt  out  CNT_W  total fails; saturates at all-ones.
- busy  out  SLOTS  per-slot occupancy.

## Operation
- Each slot is an FSM: IDLE -> COUNTING -> AWAIT_C -> IDLE. Each slot holds an 8-bit b counter and a timeout counter of width clog2(TIMEOUT+1).
- **Allocation.** At an edge with a=1 and en=1, the lowest-index IDLE slot is allocated and enters COUNTING with its b counter at 0.
  - The b value at the allocation edge is not counted (|=> semantics).
  - If no slot is IDLE, overflow pulses and the attempt is discarded.
- **COUNTING.** Each edge with b=1 increments the counter. When the increment reaches COUNT, the slot goes to AWAIT_C.
- **AWAIT_C, MODE 0.** Exactly one edge is evaluated: c=1 gives pass, c=0 gives fail. The slot then returns to IDLE.
- **AWAIT_C, MODE 1.** At each edge:
  - c=1 gives pass (c is checked first).
  - Otherwise b=1 gives fail.
  - Otherwise the slot stays in AWAIT_C.
- **Timeout.** With TIMEOUT>0, an attempt with no verdict after TIMEOUT edges following allocation fails and sets timeout. If c resolves the attempt at that same edge, pass wins.
- **Simultaneous verdicts.** pass, fail and timeout are ORs across slots. The counters add the number of slots reaching each verdict at that edge (popcount), saturating.
- **Slot release.** A slot that reaches a verdict at edge V is IDLE after V. It can be reallocated at V+1 at the earliest, not at V.
- **clr.** Highest priority: all slots go IDLE, counters go to 0, and pulse outputs are 0 at the next cycle. A trigger on the same edge is ignored.

## Timing
- Reset values: all slots IDLE; pass, fail, timeout, overflow = 0; pass_cnt = fail_cnt = 0; busy = 0.
- Reset is asynchronous; an assertion mid-attempt aborts all slots with no verdict pulse.
- Verdict latency, MODE 0: trigger at edge T with the COUNT-th b at edge T+k (k ≥ COUNT) gives c sampled at T+k+1. pass or fail is registered and high during the cycle following T+k+1, for exactly one cycle per verdict edge.
- busy[i] rises after the allocation edge and falls after the verdict edge.
- overflow is high for one cycle after the dropping edge.

## Test plan
- **MODE 0 pass:**
  - Stimulus: a=1 at edge 0 only; b=1 at edges 1, 2, 3; c=1 at edge 4.
  - Required: pass=1 in the cycle after edge 4; pass_cnt=1; busy[0] high only during edges 1–4.
- **MODE 0 fail with overlap:**
  - Stimulus: a held 1 over edges 0–5; b=1 at edges 1–3; c=0 at edge 4; c=1 at edge 5.
  - Required: slot 0 fails at edge 4.
  - Slots 1–3 (allocated at edges 1–3) still count.
  - Edge 4 is dropped (overflow=1, SLOTS=4).
- **Goto with gaps, COUNT=3:**
  - Stimulus: b=1 at edges 2, 5, 9; c=1 at edge 10.
  - Required: pass.
  - Variant with c=1 at edge 11 but c=0 at edge 10: fail.
- **MODE 1:**
  - Stimulus: b=1 at edges 1, 2, 3; c=1 at edge 7; b=0 over edges 4–6.
  - Required: pass.
  - Repeat with b=1 at edge 5: fail at edge 5.
- **Timeout (TIMEOUT=6):**
  - Stimulus: trigger with only 2 b's.
  - Required: fail=1 and timeout=1 after edge 6.
  - busy clears; fail_cnt=1.
- **Reset and clr:**
  - Stimulus: rst_n pulled low mid-COUNTING.
  - Required: all outputs 0 with no verdict.
  - Stimulus: clr and a together at one edge, with pass_cnt at 5.
  - Required: counters 0, busy=0, no new attempt.
  - Stimulus: pass_cnt preloaded to near all-ones.
  - Required: counters saturate at all-ones.
